// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
// Handshaked sequencing controller for the 8x8 unsigned multiply path.
// Two operand bytes arrive on ui_in, qualified by in_valid:
//   - the first byte is X;
//   - the second byte is Y.
// An 8-cycle radix-2 shift-add multiply then runs. The 16-bit product is held
// and presented one byte at a time on uo_out until the host acknowledges it.
//
// Ports
//   clk      in   tile clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   tile enable; 0 freezes every register
//   ui_in    in   [7:0] operand byte (X in IDLE, Y in WAIT_Y)
//   uio_in   in   [7:0] bit0 in_valid, bit1 out_sel, bit2 out_ack, bit3 clear
//   uo_out   out  [7:0] product byte chosen by out_sel
//   uio_out  out  [7:0] bit4 busy, bit5 done, bit6 wait_y, bit7 hi_nz
//   uio_oe   out  [7:0] constant 8'hF0 (upper nibble driven as status)
module mult_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_Y = 2'd1,
        S_MUL    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_x;
    logic [2:0]  r_cnt;
    logic [16:0] r_acc;
    logic [15:0] r_prod;

    logic        w_in_valid;
    logic        w_out_sel;
    logic        w_out_ack;
    logic        w_clear;
    logic [8:0]  w_addend;
    logic [8:0]  w_sum;
    logic [16:0] w_acc_next;
    logic [4:0]  w_unused;

    assign w_in_valid = uio_in[0];
    assign w_out_sel  = uio_in[1];
    assign w_out_ack  = uio_in[2];
    assign w_clear    = uio_in[3];

    // The upper uio_in bits carry no function. acc[16] is always zero once
    // it has been shifted, so only the next-value path uses the carry.
    assign w_unused = {uio_in[7:4], r_acc[16]};

    // One shift-add iteration. The multiplier sits in acc[7:0] and is
    // consumed LSB first. The partial product builds up in acc[15:8]. The
    // 9-bit sum keeps the carry, and the right shift folds it back into
    // bit 15.
    assign w_addend   = r_acc[0] ? {1'b0, r_x} : 9'd0;
    assign w_sum      = {1'b0, r_acc[15:8]} + w_addend;
    assign w_acc_next = {1'b0, w_sum, r_acc[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= 8'd0;
            r_cnt   <= 3'd0;
            r_acc   <= 17'd0;
            r_prod  <= 16'd0;
        end else if (ena) begin
            if (w_clear) begin
                // clear wins over in_valid and out_ack in the same cycle
                r_state <= S_IDLE;
                r_x     <= 8'd0;
                r_cnt   <= 3'd0;
                r_acc   <= 17'd0;
                r_prod  <= 16'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_in_valid) begin
                            r_x     <= ui_in;
                            r_state <= S_WAIT_Y;
                        end
                    end
                    S_WAIT_Y: begin
                        if (w_in_valid) begin
                            r_acc   <= {9'd0, ui_in};
                            r_cnt   <= 3'd0;
                            r_state <= S_MUL;
                        end
                    end
                    S_MUL: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 3'd1;
                        // The eighth iteration's result goes straight into prod.
                        if (r_cnt == 3'd7) begin
                            r_prod  <= w_acc_next[15:0];
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (w_out_ack) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // uo_out muxes the registered product, so out_sel can be changed
    // between edges and the other byte appears immediately.
    assign uo_out  = w_out_sel ? r_prod[15:8] : r_prod[7:0];
    assign uio_out = {(r_prod[15:8] != 8'd0),
                      (r_state == S_WAIT_Y),
                      (r_state == S_DONE),
                      (r_state == S_MUL),
                      4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl: table-driven operand pairs, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_mult_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic       iv = 1'b0;
    logic       sel = 1'b0;
    logic       ack = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] junk = 4'd0;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign uio_in = {junk, clr, ack, sel, iv};

    mult_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 waiting for Y, 2 multiplying, 3 done.
    // The product is plain arithmetic x*y, published after 8 busy cycles.
    int          m_phase;
    int          m_left;
    logic [7:0]  m_x;
    logic [7:0]  m_y;
    logic [15:0] m_prod;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_x     = 8'd0;
        m_y     = 8'd0;
        m_prod  = 16'd0;
    endtask

    function automatic logic [23:0] model_out();
        logic [7:0] uo;
        logic [7:0] st;
        uo = sel ? m_prod[15:8] : m_prod[7:0];
        st = {(m_prod[15:8] != 8'd0), (m_phase == 1), (m_phase == 3), (m_phase == 2), 4'b0000};
        return {uo, st, 8'hF0};
    endfunction

    // Advance one clock edge, update the model with the inputs seen at that
    // edge, then compare all outputs 1 ns later.
    task automatic cycle(input string name);
        logic       c_iv, c_ack, c_clr, c_ena;
        logic [7:0] c_ui;
        c_iv = iv; c_ack = ack; c_clr = clr; c_ena = ena; c_ui = ui_in;
        @(posedge clk);
        #1;
        if (rst_n && c_ena) begin
            if (c_clr) begin
                model_reset();
            end else if (m_phase == 0) begin
                if (c_iv) begin m_x = c_ui; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (c_iv) begin m_y = c_ui; m_left = 8; m_phase = 2; end
            end else if (m_phase == 2) begin
                m_left--;
                if (m_left == 0) begin
                    m_prod  = 16'(m_x) * 16'(m_y);
                    m_phase = 3;
                end
            end else begin
                if (c_ack) m_phase = 0;
            end
        end
        check(name, 32'(model_out()), 32'({uo_out, uio_out, uio_oe}));
    endtask

    // Load X and Y on consecutive edges, then wait for done and read the product.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] p,
                          input string name);
        int edges;
        int busy_cnt;
        iv = 1'b1; ui_in = x; cycle({name, "_x"});
        ui_in = y; cycle({name, "_y"});
        iv = 1'b0; ui_in = 8'($urandom);
        edges = 1;
        busy_cnt = uio_out[4] ? 1 : 0;
        while (!uio_out[5] && edges < 40) begin
            cycle({name, "_mul"});
            edges++;
            if (uio_out[4]) busy_cnt++;
        end
        check({name, "_latency"}, 32'(edges), 32'd9);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        sel = 1'b0; #1;
        check({name, "_lo"}, 32'(uo_out), 32'(p[7:0]));
        sel = 1'b1; #1;
        check({name, "_hi"}, 32'(uo_out), 32'(p[15:8]));
        check({name, "_hi_nz"}, 32'(uio_out[7]), 32'(p[15:8] != 8'd0));
        ack = 1'b1; cycle({name, "_ack"});
        ack = 1'b0;
        check({name, "_idle_after_ack"}, 32'(uio_out[6:4]), 32'd0);
    endtask

    // Pull rst_n low between edges and confirm the outputs clear at once.
    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({name, "_uo_out"}, 32'(uo_out), 32'd0);
        check({name, "_uio_out"}, 32'(uio_out), 32'd0);
        check({name, "_uio_oe"}, 32'(uio_oe), 32'hF0);
        iv = 1'b1; ui_in = 8'h99;
        cycle({name, "_held"});
        iv = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        tbl[0] = '{8'h0D, 8'h0B, 16'h008F};
        tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{8'h12, 8'h34, 16'h03A8};
        tbl[3] = '{8'hA5, 8'h3C, 16'h26AC};
        tbl[4] = '{8'h01, 8'hFF, 16'h00FF};
        tbl[5] = '{8'h80, 8'h02, 16'h0100};
        tbl[6] = '{8'hFF, 8'h01, 16'h00FF};
        tbl[7] = '{8'h10, 8'h10, 16'h0100};

        model_reset();
        #3;
        check("reset_uo_out", 32'(uo_out), 32'd0);
        check("reset_uio_out", 32'(uio_out), 32'd0);
        check("reset_uio_oe", 32'(uio_oe), 32'hF0);
        #9;
        rst_n = 1'b1;
        cycle("idle_after_reset");

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].p, $sformatf("vec%0d", i));
        end

        // Zero product held in DONE for 20 cycles without ack.
        iv = 1'b1; ui_in = 8'h00; cycle("zero_x");
        ui_in = 8'h55; cycle("zero_y");
        iv = 1'b0;
        for (int i = 0; i < 8; i++) cycle("zero_mul");
        for (int i = 0; i < 20; i++) cycle("zero_hold");
        check("zero_hold_status", 32'(uio_out), 32'h20);
        check("zero_hold_prod", 32'(uo_out), 32'd0);
        ack = 1'b1; cycle("zero_ack");
        ack = 1'b0;
        check("zero_after_ack", 32'({uo_out, uio_out}), 32'd0);

        // Clear in the 4th MUL cycle while in_valid is also high.
        run_op(8'hFF, 8'hFF, 16'hFE01, "clr_setup");
        iv = 1'b1; ui_in = 8'h12; cycle("clr_x");
        ui_in = 8'h34; cycle("clr_y");
        for (int i = 0; i < 3; i++) cycle("clr_mul");
        clr = 1'b1; ui_in = 8'h77; cycle("clr_edge");
        clr = 1'b0; iv = 1'b0;
        check("clr_status", 32'(uio_out), 32'd0);
        sel = 1'b1; #1;
        check("clr_prod_hi", 32'(uo_out), 32'd0);
        cycle("clr_no_recapture");
        check("clr_still_idle", 32'(uio_out[6]), 32'd0);
        run_op(8'h12, 8'h34, 16'h03A8, "clr_rerun");

        // Enable stall: ena low for 3 cycles during MUL.
        iv = 1'b1; ui_in = 8'hA5; cycle("stall_x");
        ui_in = 8'h3C; cycle("stall_y");
        iv = 1'b0;
        edges = 1;
        for (int i = 0; i < 2; i++) begin cycle("stall_mul"); edges++; end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin cycle("stall_off"); edges++; end
        ena = 1'b1;
        while (!uio_out[5] && edges < 40) begin cycle("stall_run"); edges++; end
        check("stall_latency", 32'(edges), 32'd12);
        sel = 1'b0; #1;
        check("stall_lo", 32'(uo_out), 32'hAC);
        sel = 1'b1; #1;
        check("stall_hi", 32'(uo_out), 32'h26);
        ack = 1'b1; cycle("stall_ack");
        ack = 1'b0;

        // Async reset in WAIT_Y, then in MUL.
        iv = 1'b1; ui_in = 8'h21; cycle("rst_wy_x");
        iv = 1'b0;
        async_reset("rst_wait_y");
        cycle("rst_wy_idle");
        iv = 1'b1; ui_in = 8'hFF; cycle("rst_mul_x");
        ui_in = 8'hFF; cycle("rst_mul_y");
        iv = 1'b0;
        for (int i = 0; i < 3; i++) cycle("rst_mul_run");
        async_reset("rst_mul");
        run_op(8'h0D, 8'h0B, 16'h008F, "post_reset");

        // Randomized traffic against the model, including ignored uio_in bits.
        for (int i = 0; i < 1500; i++) begin
            iv    = ($urandom_range(0, 1) == 1);
            ui_in = 8'($urandom);
            sel   = ($urandom_range(0, 1) == 1);
            ack   = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 40) == 0);
            ena   = ($urandom_range(0, 9) != 0);
            junk  = 4'($urandom);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
